// File: rtl/ugt_share_arbiter_pkg.sv
// rtl/ugt_share_arbiter_pkg.sv - shared state encoding, counter width and operand slicing helper
package ugt_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int DONE_CNT_W = 8;

    function automatic int operand_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ugt_share_arbiter_rr_pick.sv
// rtl/ugt_share_arbiter_rr_pick.sv - round-robin first-set search starting at the pointer
module ugt_share_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_valid
);

    logic [IDW-1:0] cand;

    // Walk from the farthest candidate back to ptr so the closest valid one wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ugt_share_arbiter.sv
// rtl/ugt_share_arbiter.sv - time-shares one unsigned greater-than comparator among NREQ requesters
module ugt_share_arbiter
    import ugt_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [NREQ-1:0]         REQ_VALID,
    output logic [NREQ-1:0]         REQ_READY,
    input  logic [NREQ*WIDTH-1:0]   REQ_I0,
    input  logic [NREQ*WIDTH-1:0]   REQ_I1,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [IDW-1:0]          RSP_ID,
    output logic                    RSP_O,
    output logic                    BUSY,
    output logic [DONE_CNT_W-1:0]   DONE_CNT
);

    arb_state_t             state_q, state_d;
    logic [IDW-1:0]         ptr_q;
    logic [IDW-1:0]         id_q;
    logic [WIDTH-1:0]       op0_q, op1_q;
    logic                   rsp_valid_q, rsp_o_q;
    logic [IDW-1:0]         rsp_id_q;
    logic [DONE_CNT_W-1:0]  done_cnt_q;
    logic [IDW-1:0]         grant;
    logic                   any_valid;
    logic [WIDTH:0]         diff;

    ugt_share_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid     (REQ_VALID),
        .ptr       (ptr_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    // op1 - op0: carry-out set means op1 >= op0, so its inverse is op0 > op1.
    assign diff = {1'b0, op1_q} + {1'b0, ~op0_q} + (WIDTH + 1)'(1);

    always_comb begin
        state_d   = state_q;
        REQ_READY = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_CMP;
                    if (RESETN) begin
                        REQ_READY[grant] = 1'b1;
                    end
                end
            end
            ST_CMP:  state_d = ST_RESP;
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op0_q       <= '0;
            op1_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_o_q     <= 1'b0;
            rsp_id_q    <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && any_valid) begin
                op0_q <= REQ_I0[operand_lsb(int'(grant), WIDTH) +: WIDTH];
                op1_q <= REQ_I1[operand_lsb(int'(grant), WIDTH) +: WIDTH];
                id_q  <= grant;
                ptr_q <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
            end
            if (state_q == ST_CMP) begin
                rsp_o_q     <= ~diff[WIDTH];
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end
            if (state_q == ST_RESP && RSP_READY) begin
                rsp_valid_q <= 1'b0;
                done_cnt_q  <= done_cnt_q + 1'b1;
            end
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_O     = rsp_o_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE_CNT  = done_cnt_q;

endmodule

// File: tb/tb_ugt_share_arbiter.sv
// tb/tb_ugt_share_arbiter.sv - self-checking bench for ugt_share_arbiter
module tb_ugt_share_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  CLK = 1'b0;
    logic                  RESETN;
    logic [NREQ-1:0]       REQ_VALID;
    logic [NREQ-1:0]       REQ_READY;
    logic [NREQ*WIDTH-1:0] REQ_I0, REQ_I1;
    logic                  RSP_VALID, RSP_READY, RSP_O, BUSY;
    logic [IDW-1:0]        RSP_ID;
    logic [7:0]            DONE_CNT;

    ugt_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .CLK(CLK), .RESETN(RESETN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_I0(REQ_I0), .REQ_I1(REQ_I1), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_ID(RSP_ID), .RSP_O(RSP_O), .BUSY(BUSY), .DONE_CNT(DONE_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus
    logic [NREQ-1:0]  s_valid = '0;
    logic [WIDTH-1:0] s_i0 [NREQ];
    logic [WIDTH-1:0] s_i1 [NREQ];
    bit               s_rready = 1'b1;
    bit               s_resetn = 1'b0;
    bit               auto_drop = 1'b0;

    // transaction-level reference: phase 0 idle, 1 comparing, 2 answering
    int m_phase = 0, m_ptr = 0, m_op0 = 0, m_op1 = 0, m_id = 0;
    int m_rv = 0, m_rid = 0, m_ro = 0, m_cnt = 0;
    int cyc = 0;
    int grants[$];
    int grant_cyc[$];

    logic [NREQ-1:0] obs_ready;
    logic            obs_rv, obs_ro, obs_busy;
    logic [IDW-1:0]  obs_rid;
    logic [7:0]      obs_done;

    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_ready;
        @(negedge CLK);
        RESETN    = s_resetn;
        RSP_READY = s_rready;
        REQ_VALID = s_valid;
        for (int i = 0; i < NREQ; i++) begin
            REQ_I0[i*WIDTH +: WIDTH] = s_i0[i];
            REQ_I1[i*WIDTH +: WIDTH] = s_i1[i];
        end
        #1;
        g = -1;
        if (s_resetn && m_phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && s_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
        obs_ready = REQ_READY; obs_rv = RSP_VALID; obs_ro = RSP_O;
        obs_rid = RSP_ID; obs_busy = BUSY; obs_done = DONE_CNT;
        check("req_ready", 32'(obs_ready), 32'(exp_ready));
        check("rsp_valid", 32'(obs_rv), 32'(m_rv));
        check("busy", 32'(obs_busy), 32'(m_phase != 0));
        check("done_cnt", 32'(obs_done), 32'(m_cnt));
        if (m_rv != 0) begin
            check("rsp_id", 32'(obs_rid), 32'(m_rid));
            check("rsp_o", 32'(obs_ro), 32'(m_ro));
        end
        @(posedge CLK);
        if (!s_resetn) begin
            m_phase = 0; m_ptr = 0; m_rv = 0; m_rid = 0; m_ro = 0; m_cnt = 0;
        end else begin
            case (m_phase)
                0: if (g >= 0) begin
                    m_op0 = int'(s_i0[g]); m_op1 = int'(s_i1[g]); m_id = g;
                    m_ptr = (g + 1) % NREQ; m_phase = 1;
                    grants.push_back(g); grant_cyc.push_back(cyc);
                    if (auto_drop) s_valid[g] = 1'b0;
                end
                1: begin
                    m_ro = (m_op0 > m_op1) ? 1 : 0; m_rid = m_id; m_rv = 1; m_phase = 2;
                end
                default: if (s_rready) begin
                    m_rv = 0; m_cnt = (m_cnt + 1) % 256; m_phase = 0;
                end
            endcase
        end
        cyc++;
    endtask

    task automatic run_one(input int req, input int a, input int b, input int exp);
        s_valid = '0; s_valid[req] = 1'b1;
        s_i0[req] = WIDTH'(a); s_i1[req] = WIDTH'(b); s_rready = 1'b1;
        cycle();
        check("grant_onehot", 32'(obs_ready), 32'(1 << req));
        s_valid = '0;
        cycle();
        cycle();
        check("one_valid", 32'(obs_rv), 32'd1);
        check("one_id", 32'(obs_rid), 32'(req));
        check("one_result", 32'(obs_ro), 32'(exp));
        cycle();
    endtask

    task automatic do_reset();
        s_resetn = 1'b0; cycle(); s_resetn = 1'b1;
        grants.delete(); grant_cyc.delete();
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < NREQ; i++) begin s_i0[i] = '0; s_i1[i] = '0; end

        // reset state, with requests pending to show REQ_READY is held low
        s_valid = '1; s_resetn = 1'b0;
        cycle(); cycle();
        check("rst_ready", 32'(obs_ready), 32'd0);
        check("rst_rsp_valid", 32'(obs_rv), 32'd0);
        check("rst_rsp_id", 32'(obs_rid), 32'd0);
        check("rst_rsp_o", 32'(obs_ro), 32'd0);
        check("rst_busy", 32'(obs_busy), 32'd0);
        check("rst_done", 32'(obs_done), 32'd0);
        s_valid = '0; s_resetn = 1'b1;
        cycle();

        // single request and comparator boundaries
        run_one(2, 9, 3, 1);
        check("single_done", 32'(obs_done), 32'd1);
        run_one(1, 15, 0, 1);
        run_one(3, 0, 15, 0);
        run_one(0, 7, 7, 0);
        run_one(2, 8, 7, 1);

        // round-robin with all requesters held
        do_reset();
        s_valid = '1;
        for (int i = 0; i < 15; i++) cycle();
        check("rr_count", 32'(grants.size()), 32'd5);
        if (grants.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("rr_order", 32'(grants[i]), 32'(i % NREQ));
                if (i > 0) check("rr_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
            end
        end

        // pointer at 2, then 1011 pending: 3 wins, then wraps to 0
        do_reset();
        s_valid = '1;
        for (int i = 0; i < 6; i++) cycle();
        s_valid = 4'b1011;
        for (int i = 0; i < 6; i++) cycle();
        check("rr_wrap_count", 32'(grants.size()), 32'd4);
        if (grants.size() == 4) begin
            check("rr_wrap_g2", 32'(grants[2]), 32'd3);
            check("rr_wrap_g3", 32'(grants[3]), 32'd0);
        end
        s_valid = '0;
        for (int i = 0; i < 4; i++) cycle();

        // backpressure
        s_valid = 4'b0001; s_i0[0] = 4'd5; s_i1[0] = 4'd2; s_rready = 1'b0;
        cycle();
        s_valid = 4'b1110;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_valid", 32'(obs_rv), 32'd1);
            check("bp_hold", {obs_ready, obs_busy, obs_rid, obs_ro}, {4'b0000, 1'b1, 2'd0, 1'b1});
        end
        s_rready = 1'b1;
        cycle();
        s_valid = '0;
        cycle();
        check("bp_idle", 32'(obs_busy), 32'd0);

        // reset while comparing, requester 3 keeps asking
        s_valid = 4'b1000; s_i0[3] = 4'd12; s_i1[3] = 4'd4;
        cycle();
        s_resetn = 1'b0;
        cycle();
        check("midrst_ready", 32'(obs_ready), 32'd0);
        s_resetn = 1'b1;
        cycle();
        check("midrst_rv", 32'(obs_rv), 32'd0);
        check("midrst_done", 32'(obs_done), 32'd0);
        check("midrst_regrant", 32'(obs_ready), 32'b1000);
        s_valid = '0;
        for (int i = 0; i < 3; i++) cycle();

        // randomized traffic
        auto_drop = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (s_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) s_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    s_valid[i] = 1'b1; s_i0[i] = rand_operand(); s_i1[i] = rand_operand();
                end
            end
            s_rready = ($urandom_range(0, 3) != 0);
            s_resetn = ($urandom_range(0, 499) != 0);
            cycle();
        end
        auto_drop = 1'b0;
        s_resetn = 1'b1; s_rready = 1'b1;

        // DONE_CNT wrap
        do_reset();
        s_valid = '1;
        for (int i = 0; i < 766; i++) cycle();
        check("wrap_255", 32'(obs_done), 32'd255);
        for (int i = 0; i < 3; i++) cycle();
        check("wrap_0", 32'(obs_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
